// File: rtl/pio_key_event_sequencer.sv
// pio_key_event_sequencer: services a push-button PIO over Avalon-MM and queues timestamped key events
module pio_key_event_sequencer #(
    parameter logic [1:0] KEY_MASK    = 2'b11,
    parameter int         TS_W        = 16,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLDOFF_CYC = 50000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            pio_irq,
    output logic [1:0]      pio_address,
    output logic            pio_chipselect,
    output logic            pio_write_n,
    output logic [31:0]     pio_writedata,
    input  logic [31:0]     pio_readdata,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [TS_W+3:0] ev_data,
    output logic            ovf,
    input  logic            clr_ovf,
    output logic            busy
);
    localparam logic [3:0] INIT = 4'd0, IDLE = 4'd1, RD_EC = 4'd2, WAIT_EC = 4'd3, CLR_EC = 4'd4,
                           RD_DAT = 4'd5, WAIT_DAT = 4'd6, PUSH = 4'd7, HOLD = 4'd8;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int HOLD_MAX = HOLDOFF_CYC > 0 ? HOLDOFF_CYC - 1 : 0;
    localparam int HC_W     = HOLD_MAX > 0 ? $clog2(HOLD_MAX + 1) : 1;

    logic [3:0]      state_q, state_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [TS_W-1:0] ts_q, ts_d, ev_ts_q, ev_ts_d;
    logic [1:0]      edges_q, edges_d, level_q, level_d, addr_q, addr_d;
    logic            cs_q, cs_d, wn_q, wn_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [31:0]     wd_q, wd_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [TS_W+3:0] mem_q [FIFO_DEPTH];
    logic [TS_W+3:0] mem_d [FIFO_DEPTH];
    logic            pop, hit, push, drop, full, unused_rd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:     state_d = busy_q ? IDLE : INIT;
            IDLE:     state_d = (en && pio_irq) ? RD_EC : IDLE;
            RD_EC:    state_d = WAIT_EC;
            WAIT_EC:  state_d = CLR_EC;
            CLR_EC:   state_d = RD_DAT;
            RD_DAT:   state_d = WAIT_DAT;
            WAIT_DAT: state_d = PUSH;
            PUSH:     state_d = (edges_q == 2'b00 || HOLDOFF_CYC == 0) ? IDLE : HOLD;
            HOLD:     state_d = (hold_q == HC_W'(HOLD_MAX)) ? IDLE : HOLD;
            default:  state_d = INIT;
        endcase
    end

    // Bus strobes are registered from the next state so they line up with state_q yet stay idle in reset
    always_comb begin
        cs_d    = state_d inside {INIT, RD_EC, CLR_EC, RD_DAT};
        wn_d    = !(state_d inside {INIT, CLR_EC});
        addr_d  = state_d == INIT ? 2'd2 : state_d inside {RD_EC, CLR_EC} ? 2'd3 : state_d == RD_DAT ? 2'd0 : addr_q;
        wd_d    = state_d == INIT ? 32'(KEY_MASK) : 32'd0;
        busy_d  = state_d != IDLE;
        hold_d  = state_q == HOLD ? hold_q + 1'b1 : '0;
        ts_d    = ts_q + 1'b1;
        ev_ts_d = state_q == RD_EC ? ts_q : ev_ts_q;
        edges_d = state_q == WAIT_EC ? pio_readdata[1:0] : edges_q;
        level_d = state_q == WAIT_DAT ? pio_readdata[1:0] : level_q;
    end

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    always_comb begin
        full  = cnt_q == (AW+1)'(FIFO_DEPTH);
        pop   = ev_valid && ev_ready;
        hit   = state_q == PUSH && edges_q != 2'b00;
        push  = hit && (!full || pop);
        drop  = hit && full && !pop;
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d = drop || (ovf_q && !clr_ovf);
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {ev_ts_q, edges_q, level_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            hold_q  <= '0;
            ts_q    <= '0;
            ev_ts_q <= '0;
            edges_q <= '0;
            level_q <= '0;
            addr_q  <= '0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ts_q    <= ts_d;
            ev_ts_q <= ev_ts_d;
            edges_q <= edges_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wd_q;
    assign ev_valid       = cnt_q != '0;
    assign ev_data        = mem_q[rd_q];
    assign ovf            = ovf_q;
    assign busy           = busy_q;
    assign unused_rd      = ^pio_readdata[31:2];
endmodule
